imm_ext_pipe: RTL and testbench

- Parametrised, pipelined immediate-extension unit for the pipeline CPU decode/execute boundary.
- Takes an IN_W-bit immediate plus a 2-bit mode and produces an OUT_W-bit word: sign-extended, zero-extended, upper-placed (LUI), or sign-extended and shifted left 2 (branch offset).
- Results pass through a 2-entry skid buffer with valid/ready on both sides, so decode stalls and flushes are absorbed without combinational ready paths.

---
 rtl/imm_ext_pipe_pkg.sv | 12 +
 rtl/imm_ext_pipe_comb.sv | 32 +++
 rtl/imm_ext_pipe.sv | 111 +++++++++++
 tb/tb_imm_ext_pipe.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pipe_pkg.sv
// Shared mode encodings for the immediate-extension unit and the control unit
// that produces in_mode.
package imm_ext_pipe_pkg;

   localparam logic [1:0] MODE_SEXT      = 2'b00;
   localparam logic [1:0] MODE_ZEXT      = 2'b01;
   localparam logic [1:0] MODE_HI        = 2'b10;
   localparam logic [1:0] MODE_SEXT_SHL2 = 2'b11;

   localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/imm_ext_pipe_comb.sv
// Purely combinational immediate extension: sign, zero, upper-placed, or
// sign-extended branch offset shifted left by two.
module imm_ext_comb
   import imm_ext_pipe_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  imm,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] word
);

   logic [OUT_W-1:0] sextWord;
   logic [OUT_W-1:0] zextWord;

   assign sextWord = OUT_W'($signed(imm));
   assign zextWord = OUT_W'(imm);

   // HI with IN_W == OUT_W degenerates to a zero-bit shift, i.e. a pass-through.
   always_comb begin
      word = sextWord;
      case (mode)
         MODE_SEXT:      word = sextWord;
         MODE_ZEXT:      word = zextWord;
         MODE_HI:        word = zextWord << (OUT_W - IN_W);
         MODE_SEXT_SHL2: word = sextWord << 2;
         default:        word = sextWord;
      endcase
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: extension at push, then a two-entry skid buffer
// whose in_ready comes only from the registered occupancy count.
module imm_ext_pipe
   import imm_ext_pipe_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_word,
   output logic [1:0]       out_mode
);

   if (IN_W < 2 || IN_W > OUT_W) begin : g_bad_width
      $error("imm_ext_pipe: IN_W must lie in 2..OUT_W");
   end
   if (DEPTH != int'(BUF_DEPTH)) begin : g_bad_depth
      $error("imm_ext_pipe: DEPTH must be 2");
   end

   logic [OUT_W-1:0] extWord;
   logic [1:0]       countQ, countD;
   logic [OUT_W-1:0] headWordQ, headWordD, skidWordQ, skidWordD;
   logic [1:0]       headModeQ, headModeD, skidModeQ, skidModeD;
   logic             push, pop;

   imm_ext_comb #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) uExt (
      .imm  (in_imm),
      .mode (in_mode),
      .word (extWord)
   );

   assign in_ready  = (countQ < 2'd2);
   assign out_valid = (countQ != 2'd0);
   assign out_word  = headWordQ;
   assign out_mode  = headModeQ;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Head is always the oldest entry; skid only fills when head is occupied
   // and not leaving. Flush drops occupancy but leaves the data registers alone.
   always_comb begin
      countD    = countQ;
      headWordD = headWordQ;
      headModeD = headModeQ;
      skidWordD = skidWordQ;
      skidModeD = skidModeQ;
      if (flush) begin
         countD = 2'd0;
      end else begin
         case (countQ)
            2'd0: begin
               if (push) begin
                  headWordD = extWord;
                  headModeD = in_mode;
                  countD    = 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  headWordD = extWord;
                  headModeD = in_mode;
               end else if (push) begin
                  skidWordD = extWord;
                  skidModeD = in_mode;
                  countD    = 2'd2;
               end else if (pop) begin
                  countD = 2'd0;
               end
            end
            2'd2: begin
               if (pop) begin
                  headWordD = skidWordQ;
                  headModeD = skidModeQ;
                  countD    = 2'd1;
               end
            end
            default: countD = 2'd0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         countQ    <= 2'd0;
         headWordQ <= '0;
         headModeQ <= 2'd0;
         skidWordQ <= '0;
         skidModeQ <= 2'd0;
      end else begin
         countQ    <= countD;
         headWordQ <= headWordD;
         headModeQ <= headModeD;
         skidWordQ <= skidWordD;
         skidModeQ <= skidModeD;
      end
   end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: vector table, scoreboard queue, and
// hand-written backpressure, flush, async reset and width-sweep sequences.
module tb_imm_ext_pipe;

   typedef struct {
      logic [15:0] imm;
      logic [1:0]  mode;
      logic [31:0] expWord;
   } vecT;

   typedef struct {
      logic [31:0] word;
      logic [1:0]  mode;
   } sbT;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush, inValid, inReady, outValid, outReady;
   logic [15:0] inImm;
   logic [1:0]  inMode, outMode;
   logic [31:0] outWord;

   logic        p12Valid, p12Ready, p12OutValid, p32Valid, p32Ready, p32OutValid;
   logic        sweepFlush, sweepOutReady;
   logic [11:0] p12Imm;
   logic [31:0] p32Imm, p12Word, p32Word;
   logic [1:0]  p12Mode, p32Mode, p12OutMode, p32OutMode;

   int compared = 0;
   int mismatched = 0;
   sbT sbQ[$];
   vecT vecs[5];

   always #5 clk = ~clk;

   imm_ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(inValid), .in_ready(inReady), .in_imm(inImm), .in_mode(inMode),
      .out_valid(outValid), .out_ready(outReady), .out_word(outWord), .out_mode(outMode)
   );

   imm_ext_pipe #(.IN_W(12), .OUT_W(32), .DEPTH(2)) dut12 (
      .clk(clk), .reset_n(reset_n), .flush(sweepFlush),
      .in_valid(p12Valid), .in_ready(p12Ready), .in_imm(p12Imm), .in_mode(p12Mode),
      .out_valid(p12OutValid), .out_ready(sweepOutReady), .out_word(p12Word), .out_mode(p12OutMode)
   );

   imm_ext_pipe #(.IN_W(32), .OUT_W(32), .DEPTH(2)) dut32 (
      .clk(clk), .reset_n(reset_n), .flush(sweepFlush),
      .in_valid(p32Valid), .in_ready(p32Ready), .in_imm(p32Imm), .in_mode(p32Mode),
      .out_valid(p32OutValid), .out_ready(sweepOutReady), .out_word(p32Word), .out_mode(p32OutMode)
   );

   function automatic logic [31:0] refModel(input logic [15:0] imm, input logic [1:0] mode);
      case (mode)
         2'b00:   return {{16{imm[15]}}, imm};
         2'b01:   return {16'h0000, imm};
         2'b10:   return {imm, 16'h0000};
         default: return {{14{imm[15]}}, imm, 2'b00};
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One cycle: drive at the falling edge, check occupancy against the
   // scoreboard, then score the handshakes the next rising edge will perform.
   task automatic applyStimulus(input logic fl, input logic v, input logic [15:0] imm,
                                input logic [1:0] mode, input logic ordy,
                                input logic [31:0] expWord, output logic pushed);
      logic doPush, doPop;
      sbT   item;
      @(negedge clk);
      flush    = fl;
      inValid  = v;
      inImm    = imm;
      inMode   = mode;
      outReady = ordy;
      checkOutput("out_valid", {31'd0, outValid}, {31'd0, sbQ.size() != 0});
      checkOutput("in_ready", {31'd0, inReady}, {31'd0, sbQ.size() < 2});
      doPush = v && inReady;
      doPop  = outValid && ordy;
      pushed = 1'b0;
      if (fl) begin
         sbQ.delete();
      end else begin
         if (doPop && sbQ.size() != 0) begin
            item = sbQ.pop_front();
            checkOutput("out_word", outWord, item.word);
            checkOutput("out_mode", {30'd0, outMode}, {30'd0, item.mode});
         end
         if (doPush) begin
            item.word = expWord;
            item.mode = mode;
            sbQ.push_back(item);
            pushed = 1'b1;
         end
      end
   endtask

   initial begin
      logic        p;
      logic [15:0] rImm;
      logic [1:0]  rMode;
      bit          accepted;

      vecs[0] = '{16'h8001, 2'b00, 32'hFFFF8001};
      vecs[1] = '{16'h8001, 2'b01, 32'h00008001};
      vecs[2] = '{16'h1234, 2'b10, 32'h12340000};
      vecs[3] = '{16'hFFFF, 2'b11, 32'hFFFFFFFC};
      vecs[4] = '{16'h7FFF, 2'b11, 32'h0001FFFC};

      reset_n = 1'b0; flush = 1'b0; inValid = 1'b0; inImm = '0; inMode = '0; outReady = 1'b0;
      p12Valid = 1'b0; p12Imm = '0; p12Mode = '0; p32Valid = 1'b0; p32Imm = '0; p32Mode = '0;
      sweepFlush = 1'b0; sweepOutReady = 1'b1;

      #1;
      checkOutput("reset out_valid", {31'd0, outValid}, 32'd0);
      checkOutput("reset out_word", outWord, 32'd0);
      checkOutput("reset out_mode", {30'd0, outMode}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Mode coverage, one push per cycle with the consumer always ready
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b0, 1'b1, vecs[i].imm, vecs[i].mode, 1'b1, vecs[i].expWord, p);
      repeat (2) applyStimulus(1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 32'h0, p);

      // Backpressure: fill both slots, hold C, then release the consumer
      applyStimulus(1'b0, 1'b1, 16'h0001, 2'b00, 1'b0, 32'h00000001, p);
      applyStimulus(1'b0, 1'b1, 16'h0002, 2'b00, 1'b0, 32'h00000002, p);
      repeat (2) begin
         applyStimulus(1'b0, 1'b1, 16'h0003, 2'b00, 1'b0, 32'h00000003, p);
         checkOutput("C held while full", {31'd0, p}, 32'd0);
      end
      accepted = 1'b0;
      for (int i = 0; i < 10 && !accepted; i++) begin
         applyStimulus(1'b0, 1'b1, 16'h0003, 2'b00, 1'b1, 32'h00000003, p);
         accepted = p;
      end
      if (!accepted) begin
         mismatched++;
         $display("[TB] FAIL C accept: got not accepted within 10 cycles, expected accepted");
      end
      repeat (3) applyStimulus(1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 32'h0, p);

      // Random traffic exercising simultaneous push/pop at every occupancy
      for (int i = 0; i < 100; i++) begin
         rImm  = 16'($urandom);
         rMode = 2'($urandom);
         applyStimulus(1'b0, 1'($urandom), rImm, rMode, 1'($urandom), refModel(rImm, rMode), p);
      end
      repeat (3) applyStimulus(1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 32'h0, p);

      // Flush with a full buffer and a competing push
      applyStimulus(1'b0, 1'b1, 16'h1111, 2'b00, 1'b0, 32'h00001111, p);
      applyStimulus(1'b0, 1'b1, 16'h2222, 2'b01, 1'b0, 32'h00002222, p);
      applyStimulus(1'b1, 1'b1, 16'h00AA, 2'b00, 1'b0, 32'h000000AA, p);
      applyStimulus(1'b0, 1'b1, 16'h0055, 2'b01, 1'b1, 32'h00000055, p);
      checkOutput("flush out_valid", {31'd0, outValid}, 32'd0);
      checkOutput("flush in_ready", {31'd0, inReady}, 32'd1);
      repeat (2) applyStimulus(1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 32'h0, p);

      // Asynchronous reset mid-cycle with two entries held
      applyStimulus(1'b0, 1'b1, 16'h3333, 2'b00, 1'b0, 32'h00003333, p);
      applyStimulus(1'b0, 1'b1, 16'h4444, 2'b00, 1'b0, 32'h00004444, p);
      @(negedge clk);
      inValid = 1'b0;
      checkOutput("pre-reset out_valid", {31'd0, outValid}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async reset out_valid", {31'd0, outValid}, 32'd0);
      sbQ.delete();
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(1'b0, 1'b1, 16'hFFFE, 2'b00, 1'b1, 32'hFFFFFFFE, p);
      repeat (2) applyStimulus(1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 32'h0, p);

      // Width sweep: 12-bit SEXT and full-width HI pass-through
      @(negedge clk);
      p12Valid = 1'b1; p12Imm = 12'h800; p12Mode = 2'b00;
      p32Valid = 1'b1; p32Imm = 32'hDEADBEEF; p32Mode = 2'b10;
      @(negedge clk);
      p12Valid = 1'b0; p32Valid = 1'b0;
      checkOutput("w12 out_valid", {31'd0, p12OutValid}, 32'd1);
      checkOutput("w12 sext", p12Word, 32'hFFFFF800);
      checkOutput("w32 out_valid", {31'd0, p32OutValid}, 32'd1);
      checkOutput("w32 hi", p32Word, 32'hDEADBEEF);
      checkOutput("w32 mode", {30'd0, p32OutMode}, 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
